// File: rtl/alu_cmd_fifo_if.sv
// Command bus between issuing logic, the command FIFO and the 8-bit ALU.
// The FIFO uses the slave modport; the producer/ALU side uses the master modport.
interface alu_cmd_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Both sides use valid/ready handshakes. A transfer happens in a cycle
    // where valid and ready are both 1 at the rising edge. A source holds its
    // payload stable while valid=1 and ready=0. Ready never depends on valid.
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_a_i;
    logic [DATA_W-1:0] in_b_i;
    logic [OP_W-1:0]   in_op_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic [OP_W-1:0]   op_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  in_valid_i, in_a_i, in_b_i, in_op_i, out_ready_i,
        output in_ready_o, out_valid_o, a_o, b_o, op_o, count_o
    );

    modport master (
        output in_valid_i, in_a_i, in_b_i, in_op_i, out_ready_i,
        input  in_ready_o, out_valid_o, a_o, b_o, op_o, count_o
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO feeding the 8-bit ALU with {op, a, b} triples in strict order.
// Optional statistics outputs (drop_cnt_o, peak_o) exist when ALU_CMD_FIFO_STATS_EN is defined.
module alu_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    alu_cmd_fifo_if.slave            bus
`ifdef ALU_CMD_FIFO_STATS_EN
    ,
    output logic [15:0]              drop_cnt_o,
    output logic [$clog2(DEPTH):0]   peak_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OP_W + 2 * DATA_W;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full          = (r_count == CW'(DEPTH));
    assign w_empty         = (r_count == '0);
    assign bus.in_ready_o  = ~w_full;
    assign bus.out_valid_o = ~w_empty;
    assign bus.count_o     = r_count;
    assign w_push          = bus.in_valid_i & ~w_full;
    assign w_pop           = ~w_empty & bus.out_ready_i;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; the empty-gating below hides stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= {bus.in_op_i, bus.in_a_i, bus.in_b_i};
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];
    assign {bus.op_o, bus.a_o, bus.b_o} = w_head;

`ifdef ALU_CMD_FIFO_STATS_EN
    logic [15:0]   r_drop_cnt;
    logic [CW-1:0] r_peak;

    // Peak follows the next count so peak_o never lags count_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_drop_cnt <= '0;
            r_peak     <= '0;
        end else if (flush_i) begin
            r_drop_cnt <= '0;
            r_peak     <= '0;
        end else begin
            if (bus.in_valid_i && w_full && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_count_nxt > r_peak) begin
                r_peak <= w_count_nxt;
            end
        end
    end

    assign drop_cnt_o = r_drop_cnt;
    assign peak_o     = r_peak;
`endif
endmodule

// File: tb/tb_alu_cmd_fifo.sv
// Self-checking bench for alu_cmd_fifo: vector table, corner sequences and a random
// run against a queue-based reference model.
module tb_alu_cmd_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int OW    = 3;
  localparam int CW    = 3;
  localparam int EW    = OW + 2 * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW), .OP_W(OW)) u_if ();

`ifdef ALU_CMD_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
  logic [CW-1:0] peak;
`endif

  alu_cmd_fifo #(.DEPTH(DEPTH), .DATA_W(DW), .OP_W(OW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (u_if.slave)
`ifdef ALU_CMD_FIFO_STATS_EN
    ,
    .drop_cnt_o (drop_cnt),
    .peak_o     (peak)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];
  int m_drop = 0;
  int m_peak = 0;
  int total  = 0;
  int bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [EW-1:0] head;
    int n;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    chk({tag, "_ctl"}, {u_if.count_o, u_if.in_ready_o, u_if.out_valid_o},
        {CW'(n), (n != DEPTH), (n != 0)});
    chk({tag, "_head"}, {u_if.op_o, u_if.a_o, u_if.b_o}, head);
`ifdef ALU_CMD_FIFO_STATS_EN
    chk({tag, "_drop"}, drop_cnt, m_drop);
    chk({tag, "_peak"}, peak, m_peak);
`endif
  endtask

  // Applies one cycle of inputs, checks pre-edge outputs, advances the model.
  task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op, input logic rdy, input logic fl);
    logic m_push, m_pop;
    u_if.in_valid_i  = v;
    u_if.in_a_i      = a;
    u_if.in_b_i      = b;
    u_if.in_op_i     = op;
    u_if.out_ready_i = rdy;
    flush            = fl;
    #1;
    model_check("pre");
    m_push = v && (exp_q.size() < DEPTH);
    m_pop  = rdy && (exp_q.size() > 0);
    if (fl) begin
      m_drop = 0;
      m_peak = 0;
    end else if (v && exp_q.size() == DEPTH && m_drop < 65535) begin
      m_drop++;
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({op, a, b});
      if (exp_q.size() > m_peak) m_peak = exp_q.size();
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic          rdy;
    logic [CW-1:0] e_cnt;
    logic          e_rdy;
    logic          e_val;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic [OW-1:0] e_op;
  } vec_t;

  function automatic vec_t mk(input logic v, input int a, input int b, input int op,
                              input logic rdy, input int cnt, input int ea, input int eb,
                              input int eop);
    vec_t t;
    t.v     = v;
    t.a     = DW'(a);
    t.b     = DW'(b);
    t.op    = OW'(op);
    t.rdy   = rdy;
    t.e_cnt = CW'(cnt);
    t.e_rdy = (cnt != DEPTH);
    t.e_val = (cnt != 0);
    t.e_a   = DW'(ea);
    t.e_b   = DW'(eb);
    t.e_op  = OW'(eop);
    return t;
  endfunction

  vec_t tbl[10];

  initial begin
    // fill, push-while-full, drain in order, pop-while-empty
    tbl[0] = mk(1'b1, 1, 2, 0, 1'b0, 1, 1, 2, 0);
    tbl[1] = mk(1'b1, 3, 4, 1, 1'b0, 2, 1, 2, 0);
    tbl[2] = mk(1'b1, 5, 6, 2, 1'b0, 3, 1, 2, 0);
    tbl[3] = mk(1'b1, 7, 8, 3, 1'b0, 4, 1, 2, 0);
    tbl[4] = mk(1'b1, 9, 9, 4, 1'b0, 4, 1, 2, 0);
    tbl[5] = mk(1'b0, 0, 0, 0, 1'b1, 3, 3, 4, 1);
    tbl[6] = mk(1'b0, 0, 0, 0, 1'b1, 2, 5, 6, 2);
    tbl[7] = mk(1'b0, 0, 0, 0, 1'b1, 1, 7, 8, 3);
    tbl[8] = mk(1'b0, 0, 0, 0, 1'b1, 0, 0, 0, 0);
    tbl[9] = mk(1'b0, 0, 0, 0, 1'b1, 0, 0, 0, 0);

    // reset with random inputs
    u_if.in_valid_i  = 1'($urandom_range(0, 1));
    u_if.in_a_i      = DW'($urandom);
    u_if.in_b_i      = DW'($urandom);
    u_if.in_op_i     = OW'($urandom);
    u_if.out_ready_i = 1'($urandom_range(0, 1));
    flush            = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {u_if.count_o, u_if.in_ready_o, u_if.out_valid_o}, {3'd0, 1'b1, 1'b0});
    chk("reset_head", {u_if.op_o, u_if.a_o, u_if.b_o}, '0);
    u_if.in_valid_i  = 1'b0;
    u_if.out_ready_i = 1'b0;
    flush            = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d", i),
          {u_if.count_o, u_if.in_ready_o, u_if.out_valid_o, u_if.op_o, u_if.a_o, u_if.b_o},
          {tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_val, tbl[i].e_op, tbl[i].e_a, tbl[i].e_b});
    end

    // simultaneous push/pop at count 2 for 10 cycles
    cycle(1'b1, 8'h10, 8'h20, 3'd1, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 8'h21, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'(8'h30 + i), DW'(8'h60 + i), OW'(i), 1'b1, 1'b0);
      chk($sformatf("simul_cnt%0d", i), u_if.count_o, 3'd2);
    end
    chk("simul_head", {u_if.op_o, u_if.a_o, u_if.b_o}, {3'd0, 8'h38, 8'h68});

    // flush at count 3 with a push in the same cycle
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(i + 1), DW'(i + 2), OW'(i), 1'b0, 1'b0);
    u_if.in_valid_i = 1'b1;
    u_if.in_a_i     = 8'hEE;
    flush           = 1'b1;
    #1;
    chk("flush_ready_pre", u_if.in_ready_o, 1'b1);
    cycle(1'b1, 8'hEE, 8'hDD, 3'd7, 1'b0, 1'b1);
    chk("flush_ctl", {u_if.count_o, u_if.out_valid_o}, {3'd0, 1'b0});
    cycle(1'b1, 8'h42, 8'h24, 3'd6, 1'b0, 1'b0);
    chk("flush_after", {u_if.op_o, u_if.a_o, u_if.b_o}, {3'd6, 8'h42, 8'h24});

    // flush while full: ready still low in the flush cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(i), DW'(i), OW'(i), 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_full_ready", u_if.in_ready_o, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // async reset mid-burst at count 3
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hA0 + i), DW'(8'hB0 + i), OW'(i), 1'b0, 1'b0);
    u_if.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {u_if.count_o, u_if.in_ready_o, u_if.out_valid_o}, {3'd0, 1'b1, 1'b0});
    chk("arst_head", {u_if.op_o, u_if.a_o, u_if.b_o}, '0);
    exp_q.delete();
    m_drop = 0;
    m_peak = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'hAA, 8'h55, 3'd5, 1'b0, 1'b0);
    chk("arst_push", {u_if.out_valid_o, u_if.op_o, u_if.a_o, u_if.b_o}, {1'b1, 3'd5, 8'hAA, 8'h55});

`ifdef ALU_CMD_FIFO_STATS_EN
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(i), DW'(i), OW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hFF, 8'hFF, 3'd7, 1'b0, 1'b0);
    chk("stats_drop", drop_cnt, 16'd5);
    chk("stats_peak", peak, 3'd4);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("stats_flush", {drop_cnt, peak}, '0);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), OW'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
